// File: rtl/sipo_align_ctrl.sv
// Serial-to-parallel word aligner: hunts K28.5 commas, verifies word
// boundary lock and frames aligned 10-bit words for the 8b/10b decoder.
module sipo_align_ctrl #(
    parameter int LOCK_CNT = 3,
    parameter int MAX_GAP  = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic       clk_1250Mhrz,
    input  logic       rst,
    input  logic       din,
    input  logic       realign,
    output logic [9:0] dout,
    output logic       dout_valid,
    output logic       dout_k,
    output logic       locked,
    output logic       align_err
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [9:0] K_POS  = 10'b0011111010;
    localparam logic [9:0] K_NEG  = 10'b1100000101;
    localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
    localparam logic [7:0] GAP_C  = 8'(MAX_GAP);
    localparam logic [7:0] LOSS_C = 8'(LOSS_CNT);

    state_t     state_q, state_d;
    logic [9:0] sr_q, sr_d;
    logic [9:0] dout_q, dout_d;
    logic [3:0] bc_q, bc_d;
    logic [7:0] hit_q, hit_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] err_q, err_d;
    logic       dout_valid_q, dout_valid_d;
    logic       dout_k_q, dout_k_d;
    logic       locked_q, locked_d;
    logic       align_err_q, align_err_d;
    logic       comma;
    logic       aligned;

    assign comma   = (sr_q == K_POS) || (sr_q == K_NEG);
    assign aligned = (bc_q == 4'd0);

    always_comb begin
        sr_d         = {sr_q[8:0], din};
        bc_d         = (bc_q == 4'd9) ? 4'd0 : bc_q + 4'd1;
        state_d      = state_q;
        hit_d        = hit_q;
        gap_d        = gap_q;
        err_d        = err_q;
        dout_d       = dout_q;
        dout_k_d     = dout_k_q;
        dout_valid_d = 1'b0;
        align_err_d  = 1'b0;

        if (realign) begin
            state_d = HUNT;
            hit_d   = '0;
            gap_d   = '0;
            err_d   = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    // A detected comma defines the boundary: re-phase bc here
                    if (comma) begin
                        bc_d     = 4'd1;
                        hit_d    = 8'd1;
                        gap_d    = '0;
                        dout_d   = sr_q;
                        dout_k_d = 1'b1;
                        state_d  = VERIFY;
                    end
                end
                VERIFY: begin
                    if (aligned) begin
                        dout_d   = sr_q;
                        dout_k_d = comma;
                        if (comma) begin
                            hit_d = hit_q + 8'd1;
                            if (hit_d == LOCK_C) begin
                                state_d = LOCKED;
                                err_d   = '0;
                            end
                        end else begin
                            gap_d = gap_q + 8'd1;
                            if (gap_d > GAP_C) begin
                                state_d = HUNT;
                            end
                        end
                    end else if (comma) begin
                        align_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
                LOCKED: begin
                    if (aligned) begin
                        dout_d       = sr_q;
                        dout_k_d     = comma;
                        dout_valid_d = 1'b1;
                        if (comma) begin
                            err_d = '0;
                        end
                    end else if (comma) begin
                        // Stray commas only count; bc keeps its phase
                        align_err_d = 1'b1;
                        err_d       = err_q + 8'd1;
                        if (err_d == LOSS_C) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_1250Mhrz) begin
        if (rst) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            bc_q         <= '0;
            hit_q        <= '0;
            gap_q        <= '0;
            err_q        <= '0;
            dout_q       <= '0;
            dout_k_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bc_q         <= bc_d;
            hit_q        <= hit_d;
            gap_q        <= gap_d;
            err_q        <= err_d;
            dout_q       <= dout_d;
            dout_k_q     <= dout_k_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= locked_d;
            align_err_q  <= align_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_k     = dout_k_q;
    assign dout_valid = dout_valid_q;
    assign locked     = locked_q;
    assign align_err  = align_err_q;

endmodule

// File: tb/tb_sipo_align_ctrl.sv
// Bench for sipo_align_ctrl: directed scenarios plus random streams,
// checked against a bit-history / word-phase reference model.
module tb_sipo_align_ctrl;

    localparam int LOCK_CNT = 3;
    localparam int MAX_GAP  = 4;
    localparam int LOSS_CNT = 3;
    localparam logic [9:0] KP = 10'b0011111010;
    localparam logic [9:0] KN = 10'b1100000101;
    localparam logic [9:0] DW = 10'b1010101010;
    localparam logic [9:0] MA = 10'b0000110000;
    localparam logic [9:0] MB = 10'b0101000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       realign = 1'b0;
    logic [9:0] dout;
    logic       dout_valid, dout_k, locked, align_err;

    int checks = 0;
    int errors = 0;

    // Trace entries: {locked, dout_valid, align_err, dout_k, dout}
    logic [13:0] obs[$];
    logic [13:0] exp_v[$];

    logic [9:0] m_sr, m_dout;
    logic       m_kf, m_valid, m_err, m_lock;
    int         m_mode, m_k, m_anchor, m_hits, m_gaps, m_miss;

    sipo_align_ctrl dut (
        .clk_1250Mhrz(clk),
        .rst(rst),
        .din(din),
        .realign(realign),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_k(dout_k),
        .locked(locked),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    function automatic bit is_k(input logic [9:0] w);
        return (w == KP) || (w == KN);
    endfunction

    // Word phase is tracked as an anchor edge index: a word boundary
    // falls wherever (edges since reset - anchor) is a multiple of 10.
    task automatic model_edge(input logic b, input logic rl, input logic rs);
        bit k;
        int ph;
        if (rs) begin
            m_sr = '0; m_dout = '0; m_kf = 0; m_valid = 0; m_err = 0;
            m_lock = 0; m_mode = 0; m_k = 0; m_anchor = 0;
            m_hits = 0; m_gaps = 0; m_miss = 0;
            return;
        end
        k = is_k(m_sr);
        ph = (m_k - m_anchor) % 10;
        m_valid = 0;
        m_err = 0;
        if (rl) begin
            m_mode = 0; m_hits = 0; m_gaps = 0; m_miss = 0;
        end else if (m_mode == 0) begin
            if (k) begin
                m_anchor = m_k; m_hits = 1; m_gaps = 0;
                m_dout = m_sr; m_kf = 1; m_mode = 1;
            end
        end else if (ph == 0) begin
            m_dout = m_sr;
            m_kf = k;
            if (m_mode == 2) begin
                m_valid = 1;
                if (k) m_miss = 0;
            end else if (k) begin
                m_hits++;
                if (m_hits == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
            end else begin
                m_gaps++;
                if (m_gaps > MAX_GAP) m_mode = 0;
            end
        end else if (k) begin
            m_err = 1;
            if (m_mode == 1) m_mode = 0;
            else begin
                m_miss++;
                if (m_miss == LOSS_CNT) m_mode = 0;
            end
        end
        m_lock = (m_mode == 2);
        m_sr = {m_sr[8:0], b};
        m_k++;
    endtask

    task automatic tick(input logic b, input logic rl, input logic rs);
        din = b;
        realign = rl;
        rst = rs;
        @(posedge clk);
        model_edge(b, rl, rs);
        #1;
        obs.push_back({locked, dout_valid, align_err, dout_k, dout});
        exp_v.push_back({m_lock, m_valid, m_err, m_kf, m_dout});
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) tick(w[i], 1'b0, 1'b0);
    endtask

    task automatic flush();
        repeat (10) tick(1'b0, 1'b1, 1'b0);
    endtask

    function automatic int cnt(input int lo, input int hi, input int b);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (obs[i][b]) n++;
        return n;
    endfunction

    task automatic test_reset();
        int s = obs.size();
        repeat (5) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (obs[obs.size()-1] !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs got %h exp 0", obs[obs.size()-1]);
            end
        end
        repeat (10) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            checks++;
            if (obs[obs.size()-1][13:12] !== 2'b00) begin
                errors++;
                $display("FAIL reset_junk lock_valid got %b exp 00",
                         obs[obs.size()-1][13:12]);
            end
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_acquire();
        int s, t1;
        flush();
        s = obs.size();
        repeat (3) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        send_word(KP);
        t1 = obs.size() - 1;
        send_word(KP);
        send_word(KP);
        repeat (4) send_word(DW);
        checks++;
        if (obs[t1+20][13] !== 1'b0 || obs[t1+21][13] !== 1'b1) begin
            errors++;
            $display("FAIL acquire_lock_edge got %b%b exp 01",
                     obs[t1+20][13], obs[t1+21][13]);
        end
        checks++;
        if (obs[t1+21][12:0] !== {2'b00, 1'b1, KP}) begin
            errors++;
            $display("FAIL acquire_lock_word got %h exp %h", obs[t1+21][12:0], {2'b00, 1'b1, KP});
        end
        for (int p = 31; p <= 51; p += 10) begin
            checks++;
            if (obs[t1+p][12:0] !== {2'b10, 1'b0, DW}) begin
                errors++;
                $display("FAIL acquire_valid_word at %0d got %h exp %h",
                         p, obs[t1+p][12:0], {2'b10, 1'b0, DW});
            end
        end
        checks++;
        if (cnt(t1 + 1, t1 + 60, 12) !== 3) begin
            errors++;
            $display("FAIL acquire_valid_count got %0d exp 3", cnt(t1 + 1, t1 + 60, 12));
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL acquire_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_loss();
        int s = obs.size();
        repeat (3) begin
            send_word(MA);
            send_word(MB);
            send_word(DW);
        end
        checks++;
        if (cnt(s, obs.size() - 1, 11) !== 3) begin
            errors++;
            $display("FAIL loss_err_count got %0d exp 3", cnt(s, obs.size() - 1, 11));
        end
        checks++;
        if ({obs[s+73][13], obs[s+74][13], obs[s+74][11]} !== 3'b101) begin
            errors++;
            $display("FAIL loss_lock_fall got %b exp 101",
                     {obs[s+73][13], obs[s+74][13], obs[s+74][11]});
        end
        checks++;
        if (cnt(s + 74, obs.size() - 1, 12) !== 0) begin
            errors++;
            $display("FAIL loss_valid_after got %0d exp 0", cnt(s + 74, obs.size() - 1, 12));
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL loss_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_err_clear();
        int s;
        flush();
        repeat (3) send_word(KP);
        send_word(DW);
        s = obs.size();
        send_word(MA); send_word(MB); send_word(MA); send_word(MB);
        send_word(KP);
        send_word(MA); send_word(MB); send_word(MA); send_word(MB);
        send_word(DW);
        checks++;
        if (cnt(s, obs.size() - 1, 13) !== obs.size() - s) begin
            errors++;
            $display("FAIL errclr_locked got %0d exp %0d",
                     cnt(s, obs.size() - 1, 13), obs.size() - s);
        end
        checks++;
        if (cnt(s, obs.size() - 1, 11) !== 4) begin
            errors++;
            $display("FAIL errclr_err_count got %0d exp 4", cnt(s, obs.size() - 1, 11));
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL errclr_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_gap();
        logic [9:0] w[7];
        int s, t1;
        w = '{10'b1010101010, 10'b0101010101, 10'b1001001001, 10'b0100100100,
              10'b1101101101, 10'b0110110110, 10'b1010101010};
        flush();
        s = obs.size();
        send_word(KP);
        t1 = obs.size() - 1;
        for (int i = 0; i < 7; i++) send_word(w[i]);
        checks++;
        if (obs[t1+1][10:0] !== {1'b1, KP}) begin
            errors++;
            $display("FAIL gap_first_comma got %h exp %h", obs[t1+1][10:0], {1'b1, KP});
        end
        checks++;
        if (obs[t1+51][10:0] !== {1'b0, w[4]}) begin
            errors++;
            $display("FAIL gap_fifth_word got %h exp %h", obs[t1+51][10:0], {1'b0, w[4]});
        end
        checks++;
        if (obs[t1+61][9:0] !== w[4]) begin
            errors++;
            $display("FAIL gap_hunt_hold got %h exp %h", obs[t1+61][9:0], w[4]);
        end
        checks++;
        if (cnt(s, obs.size() - 1, 13) !== 0) begin
            errors++;
            $display("FAIL gap_locked got %0d exp 0", cnt(s, obs.size() - 1, 13));
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL gap_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_realign();
        int s, t1;
        flush();
        repeat (3) send_word(KP);
        repeat (2) send_word(DW);
        s = obs.size();
        for (int i = 9; i >= 0; i--) tick(DW[i], 1'(i == 6), 1'b0);
        send_word(DW);
        checks++;
        if ({obs[s+2][13], obs[s+3][13]} !== 2'b10) begin
            errors++;
            $display("FAIL realign_drop got %b exp 10", {obs[s+2][13], obs[s+3][13]});
        end
        checks++;
        if (cnt(s + 3, obs.size() - 1, 12) !== 0) begin
            errors++;
            $display("FAIL realign_valid got %0d exp 0", cnt(s + 3, obs.size() - 1, 12));
        end
        send_word(KP);
        t1 = obs.size() - 1;
        send_word(KP);
        send_word(KP);
        repeat (2) send_word(DW);
        checks++;
        if ({obs[t1+20][13], obs[t1+21][13], obs[t1+31][12]} !== 3'b011) begin
            errors++;
            $display("FAIL realign_relock got %b exp 011",
                     {obs[t1+20][13], obs[t1+21][13], obs[t1+31][12]});
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL realign_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_rst_realign();
        int s = obs.size();
        for (int i = 9; i >= 6; i--) tick(DW[i], 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs[obs.size()-1] !== 14'h0) begin
            errors++;
            $display("FAIL rstrl_outputs got %h exp 0", obs[obs.size()-1]);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs[obs.size()-1] !== 14'h0) begin
            errors++;
            $display("FAIL rstrl_after got %h exp 0", obs[obs.size()-1]);
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL rstrl_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_random();
        int s = obs.size();
        repeat (300) begin
            int r;
            logic [9:0] w;
            r = $urandom_range(0, 9);
            if (r < 6) w = $urandom_range(0, 1) ? KP : KN;
            else w = 10'($urandom);
            for (int i = 9; i >= 0; i--)
                tick(w[i], 1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1499) == 0));
            if ($urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 9)) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        for (int i = s; i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL random_trace idx %0d got %h exp %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_loss();
        test_err_clear();
        test_gap();
        test_realign();
        test_rst_realign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
